pcpi_serial_bridge: RTL

//  Parametrised serial-to-PCPI bridge; successor to the single-nibble PCPI instruction loader.
//  - Assembles a WORD_W-bit instruction from SEG_W-bit segments over a valid/ready handshake.
//  - Issues the instruction to a PCPI coprocessor and holds it until the coprocessor answers.
//  - If the coprocessor writes back, returns pcpi_rd serially over a second valid/ready channel.
//  - Sits between the chip pins (ui_in/uo_out) and the PCPI unit at the top level.

---
 rtl/pcpi_serial_bridge_pkg.sv | 18 +
 rtl/pcpi_serial_bridge_if.sv | 30 +++
 rtl/pcpi_serial_bridge_shifter.sv | 42 ++++
 rtl/pcpi_serial_bridge.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/pcpi_serial_bridge_pkg.sv
// Shared types and sizing helpers for the serial-to-PCPI bridge.
package pcpi_bridge_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        ISSUE  = 2'd1,
        RESULT = 2'd2
    } state_e;

    function automatic int nseg(input int word_w, input int seg_w);
        return word_w / seg_w;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcpi_serial_bridge_if.sv
// Host-segment, PCPI and result-segment signals of the bridge; slave is the bridge view.
interface pcpi_serial_bridge_if #(
    parameter int SEG_W  = 4,
    parameter int WORD_W = 32
);
    logic [SEG_W-1:0]  seg_in;
    logic              seg_valid;
    logic              seg_ready;
    logic              pcpi_valid;
    logic [WORD_W-1:0] pcpi_insn;
    logic              pcpi_ready;
    logic              pcpi_wr;
    logic              pcpi_wait;
    logic [WORD_W-1:0] pcpi_rd;
    logic [SEG_W-1:0]  rd_seg;
    logic              rd_valid;
    logic              rd_ready;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  seg_in, seg_valid, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, rd_ready,
        output seg_ready, pcpi_valid, pcpi_insn, rd_seg, rd_valid, busy, timeout_err
    );

    modport master (
        output seg_in, seg_valid, pcpi_ready, pcpi_wr, pcpi_wait, pcpi_rd, rd_ready,
        input  seg_ready, pcpi_valid, pcpi_insn, rd_seg, rd_valid, busy, timeout_err
    );
endinterface

// File: rtl/pcpi_serial_bridge_shifter.sv
// Segment shift register shared by instruction assembly and result return.
module pcpi_seg_shifter #(
    parameter int WORD_W = 32,
    parameter int SEG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [WORD_W-1:0] load_data_i,
    input  logic              shift_i,
    input  logic [SEG_W-1:0]  seg_i,
    output logic [WORD_W-1:0] shifted_o,
    output logic [SEG_W-1:0]  low_o
);
    logic [WORD_W-1:0] shreg_q, shreg_d;

    // New segment enters at the top so the first one lands at the bottom after a full word.
    if (WORD_W > SEG_W) begin : g_wide
        assign shifted_o = {seg_i, shreg_q[WORD_W-1:SEG_W]};
    end else begin : g_single
        assign shifted_o = seg_i;
    end

    always_comb begin
        shreg_d = shreg_q;
        if (load_i) begin
            shreg_d = load_data_i;
        end else if (shift_i) begin
            shreg_d = shifted_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign low_o = shreg_q[SEG_W-1:0];
endmodule

// File: rtl/pcpi_serial_bridge.sv
// Serial-to-PCPI bridge: segment assembly, issue, serial result return.
// Optional issue timeout enabled by defining PCPI_TIMEOUT_EN.
//   state  | meaning
//   LOAD   | accepting instruction segments
//   ISSUE  | pcpi_valid high, waiting for coprocessor
//   RESULT | returning pcpi_rd one segment at a time
module pcpi_serial_bridge
    import pcpi_bridge_pkg::*;
#(
    parameter int SEG_W   = 4,
    parameter int WORD_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pcpi_serial_bridge_if.slave  bus
);
    localparam int NSEG  = nseg(WORD_W, SEG_W);
    localparam int CNT_W = cnt_w(NSEG);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NSEG - 1);

    if (WORD_W % SEG_W != 0) begin : g_bad_width
        $error("WORD_W must be a multiple of SEG_W");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] insn_q, insn_d;
    logic              sh_load, sh_shift;
    logic [WORD_W-1:0] sh_next;
    logic [SEG_W-1:0]  sh_low;
    logic              abort;

    pcpi_seg_shifter #(.WORD_W(WORD_W), .SEG_W(SEG_W)) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (sh_load),
        .load_data_i (bus.pcpi_rd),
        .shift_i     (sh_shift),
        .seg_i       (bus.seg_in),
        .shifted_o   (sh_next),
        .low_o       (sh_low)
    );

`ifdef PCPI_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic              terr_q, terr_d;

    // Counter is held at zero outside ISSUE, so every issue starts from a clean count.
    always_comb begin
        abort  = (state_q == ISSUE) && !bus.pcpi_ready && (tcnt_q == TCNT_W'(TIMEOUT));
        tcnt_d = tcnt_q;
        if (state_q != ISSUE) begin
            tcnt_d = '0;
        end else if (!bus.pcpi_wait && !bus.pcpi_ready) begin
            tcnt_d = tcnt_q + 1'b1;
        end
        terr_d = terr_q | abort;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            terr_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            terr_q <= terr_d;
        end
    end

    assign bus.timeout_err = terr_q;
`else
    logic unused_wait;
    assign unused_wait     = bus.pcpi_wait;
    assign abort           = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        insn_d   = insn_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (bus.seg_valid) begin
                    sh_shift = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        insn_d  = sh_next;
                        state_d = ISSUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (bus.pcpi_ready) begin
                    if (bus.pcpi_wr) begin
                        sh_load = 1'b1;
                        state_d = RESULT;
                    end else begin
                        state_d = LOAD;
                    end
                end else if (abort) begin
                    state_d = LOAD;
                end
            end
            RESULT: begin
                if (bus.rd_ready) begin
                    sh_shift = 1'b1;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            insn_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            insn_q  <= insn_d;
        end
    end

    assign bus.seg_ready  = (state_q == LOAD);
    assign bus.pcpi_valid = (state_q == ISSUE);
    assign bus.pcpi_insn  = insn_q;
    assign bus.rd_valid   = (state_q == RESULT);
    assign bus.rd_seg     = (state_q == RESULT) ? sh_low : '0;
    assign bus.busy       = (state_q != LOAD);
endmodule
